multicycle_sequencer: RTL and testbench

//  Multi-cycle FSM that sequences the RV32I datapath around the combinational control_unit:

---
 rtl/riscv_pkg.sv | 43 ++++
 rtl/mem_wait_timer.sv | 34 +++
 rtl/multicycle_sequencer.sv | 179 +++++++++++++++++
 tb/tb_multicycle_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the multi-cycle RV32I control path.
//   - RV32I major opcodes (IR[6:0]) handled by the sequencer
//   - seq_state_t: sequencer FSM states
//   - pc_sel / wb_sel mux encodings
//   - is_legal_opcode(): opcode legality check used in DECODE
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } seq_state_t;

  // Next-PC source
  localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;  // PC + 4
  localparam logic [1:0] PC_SEL_IMM   = 2'b01;  // PC + imm (taken branch, jal)
  localparam logic [1:0] PC_SEL_JALR  = 2'b10;  // (rs1 + imm) & ~1

  // Register-file write-back source
  localparam logic [1:0] WB_SEL_ALU = 2'b00;
  localparam logic [1:0] WB_SEL_MEM = 2'b01;
  localparam logic [1:0] WB_SEL_PC4 = 2'b10;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR: return 1'b1;
      default:                                                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts cycles a memory request has waited for ready.
//   clk      in  clock
//   rst      in  asynchronous active-high reset (count -> 0)
//   clear    in  synchronous clear, takes priority over count_en
//   count_en in  increment this cycle
//   expired  out count has reached TIMEOUT_CYCLES-1
module mem_wait_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam int unsigned W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (count_en) begin
      count <= count + W'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: multi-cycle FSM sequencing the RV32I datapath
// (fetch, decode, execute, memory, writeback), one instruction at a time.
//   clk, rst            clock; asynchronous active-high reset
//   halt_req            stop at the next instruction boundary
//   opcode              IR[6:0]
//   cu_*                control_unit flags for the instruction in IR
//   branch_cond         branch comparison result (valid in EXEC)
//   imem_ready          instruction memory data valid
//   dmem_ready          data memory access complete
//   imem_req/dmem_req   memory requests; dmem_we marks a write
//   ir_load, pc_write   IR latch and PC update enables; pc_sel picks next PC
//   reg_write, wb_sel   register write enable and write-back source
//   retire              one-cycle pulse per completed instruction
//   retired_count       completed-instruction counter (wraps)
//   halted              FSM is in IDLE
//   trap                FSM is in TRAP (sticky until rst)
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             halt_req,
  input  logic [6:0]       opcode,
  input  logic             cu_mem_read,
  input  logic             cu_mem_write,
  input  logic             cu_reg_write,
  input  logic             cu_mem_to_reg,
  input  logic             cu_branch,
  input  logic             branch_cond,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_load,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             reg_write,
  output logic [1:0]       wb_sel,
  output logic             retire,
  output logic [CNT_W-1:0] retired_count,
  output logic             halted,
  output logic             trap
);

  seq_state_t state, state_next;
  seq_state_t boundary;
  logic       wait_clear;
  logic       wait_en;
  logic       wait_expired;
  logic       is_jal;
  logic       is_jalr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_count <= '0;
    end else if (retire) begin
      retired_count <= retired_count + CNT_W'(1);
    end
  end

  // Counter restarts on every entry into a waiting state; MEM->FETCH after a
  // store is a direct hop, so clearing on "not waiting" alone would not suffice.
  assign wait_clear = ((state_next == ST_FETCH) || (state_next == ST_MEM)) &&
                      (state_next != state);
  assign wait_en    = ((state == ST_FETCH) && !imem_ready) ||
                      ((state == ST_MEM)   && !dmem_ready);

  mem_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clear),
    .count_en(wait_en),
    .expired (wait_expired)
  );

  assign is_jal   = (opcode == OP_JAL);
  assign is_jalr  = (opcode == OP_JALR);
  assign boundary = halt_req ? ST_IDLE : ST_FETCH;

  always_comb begin
    state_next = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_load    = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = PC_SEL_PLUS4;
    reg_write  = 1'b0;
    wb_sel     = WB_SEL_ALU;
    retire     = 1'b0;
    halted     = 1'b0;
    trap       = 1'b0;

    case (state)
      ST_IDLE: begin
        halted = 1'b1;
        if (!halt_req) state_next = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_load    = 1'b1;
          state_next = ST_DECODE;
        end else if (wait_expired) begin
          state_next = ST_TRAP;
        end
      end

      ST_DECODE: begin
        state_next = is_legal_opcode(opcode) ? ST_EXEC : ST_TRAP;
      end

      ST_EXEC: begin
        if (cu_branch) begin
          pc_write   = 1'b1;
          pc_sel     = branch_cond ? PC_SEL_IMM : PC_SEL_PLUS4;
          retire     = 1'b1;
          state_next = boundary;
        end else if (cu_mem_read || cu_mem_write) begin
          state_next = ST_MEM;
        end else begin
          state_next = ST_WB;
        end
      end

      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = cu_mem_write;
        if (dmem_ready) begin
          if (cu_mem_write) begin
            pc_write   = 1'b1;
            pc_sel     = PC_SEL_PLUS4;
            retire     = 1'b1;
            state_next = boundary;
          end else begin
            state_next = ST_WB;
          end
        end else if (wait_expired) begin
          state_next = ST_TRAP;
        end
      end

      ST_WB: begin
        reg_write = cu_reg_write;
        pc_write  = 1'b1;
        if (cu_mem_to_reg)          wb_sel = WB_SEL_MEM;
        else if (is_jal || is_jalr) wb_sel = WB_SEL_PC4;
        if (is_jal)       pc_sel = PC_SEL_IMM;
        else if (is_jalr) pc_sel = PC_SEL_JALR;
        retire     = 1'b1;
        state_next = boundary;
      end

      ST_TRAP: begin
        trap = 1'b1;
      end

      default: begin
        state_next = ST_TRAP;
      end
    endcase
  end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: directed + randomized checks of multicycle_sequencer.
// Each instruction is expanded into an expected per-cycle trace (outputs plus
// the ready inputs to drive), then replayed cycle by cycle against the DUT.
module tb_multicycle_sequencer;
  import riscv_pkg::*;

  localparam int unsigned TO = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          halt_req;
  logic [6:0]    opcode;
  logic          cu_mem_read, cu_mem_write, cu_reg_write, cu_mem_to_reg, cu_branch;
  logic          branch_cond;
  logic          imem_ready, dmem_ready;
  logic          imem_req, dmem_req, dmem_we, ir_load, pc_write;
  logic [1:0]    pc_sel, wb_sel;
  logic          reg_write, retire, halted, trap;
  logic [CW-1:0] retired_count;

  always #5 clk = ~clk;

  multicycle_sequencer #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W         (CW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .halt_req     (halt_req),
    .opcode       (opcode),
    .cu_mem_read  (cu_mem_read),
    .cu_mem_write (cu_mem_write),
    .cu_reg_write (cu_reg_write),
    .cu_mem_to_reg(cu_mem_to_reg),
    .cu_branch    (cu_branch),
    .branch_cond  (branch_cond),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .imem_req     (imem_req),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .ir_load      (ir_load),
    .pc_write     (pc_write),
    .pc_sel       (pc_sel),
    .reg_write    (reg_write),
    .wb_sel       (wb_sel),
    .retire       (retire),
    .retired_count(retired_count),
    .halted       (halted),
    .trap         (trap)
  );

  typedef struct packed {
    logic       imem_req;
    logic       dmem_req;
    logic       dmem_we;
    logic       ir_load;
    logic       pc_write;
    logic [1:0] pc_sel;
    logic       reg_write;
    logic [1:0] wb_sel;
    logic       retire;
    logic       halted;
    logic       trap;
  } out_t;

  typedef struct {
    out_t       o;
    logic       ir;
    logic       dr;
    logic [6:0] op;
    logic [4:0] cu;   // {reg_write, mem_read, mem_write, mem_to_reg, branch}
    logic       bc;
  } cyc_t;

  cyc_t          tr[$];
  int unsigned   total = 0;
  int unsigned   bad   = 0;
  logic [CW-1:0] exp_count;
  logic [6:0]    cur_op;
  logic [4:0]    cur_cu;
  logic          cur_bc;

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  // Reference control_unit: which flags each opcode raises.
  function automatic logic [4:0] cu_model(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111: return 5'b10000;
      7'b0000011: return 5'b11010;
      7'b0100011: return 5'b00100;
      7'b1100011: return 5'b00001;
      default:    return 5'b00000;
    endcase
  endfunction

  function automatic void push(input out_t o, input logic ir, input logic dr);
    cyc_t c;
    c.o  = o;
    c.ir = ir;
    c.dr = dr;
    c.op = cur_op;
    c.cu = cur_cu;
    c.bc = cur_bc;
    tr.push_back(c);
  endfunction

  // Expected trace for one legal instruction: id/dd are extra wait cycles
  // before imem_ready/dmem_ready. Ready inputs outside their wait state are random.
  function automatic void build_instr(input logic [6:0] op, input int unsigned id,
                                      input int unsigned dd, input logic bc);
    out_t o;
    logic is_load, is_store, is_branch;
    cur_op    = op;
    cur_cu    = cu_model(op);
    cur_bc    = bc;
    is_load   = (op == 7'b0000011);
    is_store  = (op == 7'b0100011);
    is_branch = (op == 7'b1100011);
    for (int unsigned i = 0; i <= id; i++) begin
      o = '0; o.imem_req = 1'b1; o.ir_load = (i == id);
      push(o, i == id, rb());
    end
    o = '0; push(o, rb(), rb());                         // decode
    if (is_branch) begin
      o = '0; o.pc_write = 1'b1; o.retire = 1'b1;
      o.pc_sel = bc ? 2'b01 : 2'b00;
      push(o, rb(), rb());
    end else begin
      o = '0; push(o, rb(), rb());                       // exec
      if (is_load || is_store) begin
        for (int unsigned i = 0; i <= dd; i++) begin
          o = '0; o.dmem_req = 1'b1; o.dmem_we = is_store;
          o.pc_write = is_store && (i == dd);
          o.retire   = is_store && (i == dd);
          push(o, rb(), i == dd);
        end
      end
      if (!is_store) begin
        o = '0; o.pc_write = 1'b1; o.retire = 1'b1;
        o.reg_write = 1'b1;
        o.wb_sel = is_load ? 2'b01 : (op == 7'b1101111 || op == 7'b1100111) ? 2'b10 : 2'b00;
        o.pc_sel = (op == 7'b1101111) ? 2'b01 : (op == 7'b1100111) ? 2'b10 : 2'b00;
        push(o, rb(), rb());
      end
    end
  endfunction

  task automatic check(input string tag, input out_t e);
    logic [12+CW:0] obs, expv;
    obs  = {imem_req, dmem_req, dmem_we, ir_load, pc_write, pc_sel, reg_write,
            wb_sel, retire, halted, trap, retired_count};
    expv = {e, exp_count};
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s obs=%h exp=%h t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Replay the trace; halt_req is held from cycle hs onward (hs<0: never).
  task automatic play(input string tag, input int hs);
    for (int k = 0; k < tr.size(); k++) begin
      @(posedge clk); #1;
      imem_ready    = tr[k].ir;
      dmem_ready    = tr[k].dr;
      opcode        = tr[k].op;
      {cu_reg_write, cu_mem_read, cu_mem_write, cu_mem_to_reg, cu_branch} = tr[k].cu;
      branch_cond   = tr[k].bc;
      halt_req      = (hs >= 0) && (k >= hs);
      @(negedge clk);
      check(tag, tr[k].o);
      if (tr[k].o.retire) exp_count = exp_count + CW'(1);
    end
    tr.delete();
  endtask

  task automatic run_instr(input string tag, input logic [6:0] op, input int unsigned id,
                           input int unsigned dd, input logic bc, input logic do_halt);
    int   hs;
    out_t o;
    build_instr(op, id, dd, bc);
    hs = do_halt ? int'($urandom_range(tr.size() - 1, 0)) : -1;
    play(tag, hs);
    if (do_halt) begin
      @(posedge clk); #1;
      halt_req   = 1'b0;
      imem_ready = rb();
      dmem_ready = rb();
      @(negedge clk);
      o = '0; o.halted = 1'b1;
      check({tag, "_halted"}, o);
    end
  endtask

  task automatic do_reset(input string tag);
    out_t o;
    rst        = 1'b1;
    halt_req   = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    exp_count  = '0;
    o = '0; o.halted = 1'b1;
    #3;
    check(tag, o);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    halt_req = 1'b0;
    @(negedge clk);
    check({tag, "_idle"}, o);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] legal[7];
    out_t       o;
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b1101111, 7'b1100111};
    opcode = '0; branch_cond = 1'b0;
    {cu_reg_write, cu_mem_read, cu_mem_write, cu_mem_to_reg, cu_branch} = '0;

    do_reset("reset");

    // rst while a load waits in MEM: requests drop at once, nothing retires
    cur_op = 7'b0000011; cur_cu = cu_model(cur_op); cur_bc = 1'b0;
    o = '0; o.imem_req = 1'b1; o.ir_load = 1'b1; push(o, 1'b1, 1'b0);
    o = '0; push(o, 1'b0, 1'b0); push(o, 1'b0, 1'b0);
    o = '0; o.dmem_req = 1'b1; push(o, 1'b1, 1'b0); push(o, 1'b0, 1'b0);
    play("rst_mem_pre", -1);
    @(posedge clk); #1;
    dmem_ready = 1'b0;
    do_reset("rst_in_mem");

    run_instr("add",       7'b0110011, 0, 0, 1'b0, 1'b0);
    run_instr("lw_d3",     7'b0000011, 0, 3, 1'b0, 1'b0);
    run_instr("beq_t",     7'b1100011, 0, 0, 1'b1, 1'b0);
    run_instr("beq_nt",    7'b1100011, 0, 0, 1'b0, 1'b0);
    run_instr("jalr",      7'b1100111, 1, 0, 1'b0, 1'b0);
    run_instr("sw",        7'b0100011, 0, 2, 1'b1, 1'b0);
    run_instr("jal",       7'b1101111, 0, 0, 1'b1, 1'b0);
    run_instr("addi_i15",  7'b0010011, TO - 1, 0, 1'b0, 1'b0);
    run_instr("sw_d15",    7'b0100011, 0, TO - 1, 1'b0, 1'b0);
    run_instr("lw_d15",    7'b0000011, 2, TO - 1, 1'b0, 1'b0);
    run_instr("add_halt",  7'b0110011, 1, 0, 1'b0, 1'b1);

    for (int n = 0; n < 40; n++) begin
      run_instr("rand", legal[$urandom_range(6, 0)], $urandom_range(3, 0),
                $urandom_range(3, 0), rb(), ($urandom_range(4, 0) == 0));
    end

    // illegal opcode: TRAP after DECODE, held regardless of inputs
    do_reset("reset2");
    cur_op = 7'b0110111; cur_cu = 5'($urandom); cur_bc = rb();
    o = '0; o.imem_req = 1'b1; o.ir_load = 1'b1; push(o, 1'b1, rb());
    o = '0; push(o, rb(), rb());
    for (int i = 0; i < 6; i++) begin
      o = '0; o.trap = 1'b1; push(o, rb(), rb());
    end
    play("illegal", 3);
    do_reset("rst_after_illegal");

    // imem_ready never arrives: TO fetch cycles then TRAP
    cur_op = 7'b0110011; cur_cu = cu_model(cur_op); cur_bc = 1'b0;
    for (int i = 0; i < int'(TO); i++) begin
      o = '0; o.imem_req = 1'b1; push(o, 1'b0, rb());
    end
    for (int i = 0; i < 4; i++) begin
      o = '0; o.trap = 1'b1; push(o, rb(), rb());
    end
    play("imem_timeout", -1);
    do_reset("rst_after_itmo");

    // dmem_ready never arrives on a load: TO MEM cycles then TRAP
    cur_op = 7'b0000011; cur_cu = cu_model(cur_op); cur_bc = 1'b0;
    o = '0; o.imem_req = 1'b1; o.ir_load = 1'b1; push(o, 1'b1, rb());
    o = '0; push(o, rb(), rb()); push(o, rb(), rb());
    for (int i = 0; i < int'(TO); i++) begin
      o = '0; o.dmem_req = 1'b1; push(o, rb(), 1'b0);
    end
    for (int i = 0; i < 4; i++) begin
      o = '0; o.trap = 1'b1; push(o, rb(), rb());
    end
    play("dmem_timeout", -1);
    do_reset("rst_after_dtmo");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
